pf_ddr4_cs_n_tx_ctrl: RTL
=========================

// Module: pf_ddr4_cs_n_tx_ctrl
// PURPOSE
//  Fabric-side driver for the DDR4 CS0_N output IOD lane. Pipelines the 4-phase DFI chip-select
//  into the lane's TX_DATA/OE_DATA nibbles, forcing CS_N deasserted when idle or in reset.
//  Also sequences the lane's dynamic TX delay line: LOAD, or N single-step MOVE pulses with
//  settle gaps and out-of-range abort, under a req/busy/done handshake from the training FSM.
// PARAMETERS
//  PIPE_LAT  2  DFI_CS_N -> TX_DATA_0 register stages (legal 1..4)
//  MOVE_GAP  4  idle cycles after each MOVE/LOAD pulse before the next action (legal 1..15)
//  STEP_W    8  width of step request/count
// PORTS
//  FAB_CLK                    in   1       fabric clock (HS_IO_CLK/4 domain); all logic on rising edge
//  TX_SYNC_RST                in   1       synchronous reset, active-high
//  DFI_CS_N                   in   4       per-phase CS_N, bit0 = earliest phase; 1 = deselect
//  CS_OE                      in   1       1 = drive pad, 0 = tri-state
//  TX_DATA_0                  out  4       to IOD TX_DATA_0 (bit0 first on pad)
//  OE_DATA_0                  out  4       to IOD OE_DATA_0
//  ADJ_REQ                    in   1       start delay-line operation (sampled in IDLE only)
//  ADJ_LOAD                   in   1       with ADJ_REQ: reload default delay, steps ignored
//  ADJ_DIR                    in   1       with ADJ_REQ: step direction (1 = increase)
//  ADJ_STEPS                  in   STEP_W  with ADJ_REQ: number of MOVE pulses
//  ADJ_BUSY                   out  1       high from cycle after accept until DONE state exit
//  ADJ_DONE                   out  1       1-cycle completion pulse
//  ADJ_ERR                    out  1       out-of-range abort; valid with ADJ_DONE, held until next accept
//  ADJ_COUNT                  out  STEP_W  MOVE pulses issued in current/last operation
//  DELAY_LINE_MOVE_0          out  1       to IOD
//  DELAY_LINE_DIRECTION_0     out  1       to IOD
//  DELAY_LINE_LOAD_0          out  1       to IOD
//  DELAY_LINE_OUT_OF_RANGE_0  in   1       from IOD
// BEHAVIOUR
//  Reset values: TX_DATA_0=4'hF, OE_DATA_0=4'hF, all other outputs 0, FSM=IDLE, pipeline filled 4'hF.
//  CS path: TX_DATA_0 = DFI_CS_N delayed exactly PIPE_LAT FAB_CLK cycles, bit order preserved.
//   OE_DATA_0 = {4{CS_OE}} on same latency. No phase reordering or gating beyond reset.
//  FSM states: IDLE, SETUP, LOAD, MOVE, GAP, DONE.
//   IDLE: ADJ_REQ=1 -> latch DIR/STEPS/LOAD, clear ADJ_ERR and ADJ_COUNT, go SETUP.
//   SETUP (1 cycle): DELAY_LINE_DIRECTION_0 <= latched DIR (held stable until IDLE);
//     LOAD set -> LOAD; else STEPS==0 -> DONE; else -> MOVE.
//   LOAD (1 cycle): DELAY_LINE_LOAD_0=1 -> GAP.
//   MOVE (1 cycle): DELAY_LINE_MOVE_0=1, ADJ_COUNT+1 -> GAP.
//   GAP: MOVE_GAP cycles, counter restarts on entry. OUT_OF_RANGE=1 on any GAP cycle -> ADJ_ERR=1, DONE
//     immediately. End of gap: LOAD op or COUNT==STEPS -> DONE, else MOVE.
//   DONE (1 cycle): ADJ_DONE=1 -> IDLE.
//  MOVE/LOAD are never high on consecutive cycles; each pulse exactly 1 cycle.
//  ADJ_REQ while busy: ignored (no queueing). ADJ_REQ in DONE cycle: ignored.
//  OUT_OF_RANGE outside GAP: ignored. ADJ_COUNT saturates impossible (bounded by STEPS).
//  CS path and adjust FSM are independent; adjust never alters TX/OE data.
//  TX_SYNC_RST mid-operation: next edge returns all to reset values; no ADJ_DONE pulse.
// TESTING
//  1 Reset release, DFI_CS_N=F, CS_OE=1, then 4'hE for 1 cycle -> TX_DATA_0=E exactly 2 cycles later, F otherwise.
//  2 REQ DIR=1 STEPS=3 -> 3 MOVE pulses 5 cycles apart, DIR high from SETUP, DONE with COUNT=3, ERR=0.
//  3 REQ STEPS=5, OUT_OF_RANGE raised in gap after 2nd MOVE -> DONE next cycle, ERR=1, COUNT=2, no 3rd MOVE.
//  4 REQ LOAD=1 STEPS=7 -> single LOAD pulse, no MOVE, DONE after MOVE_GAP, COUNT=0.
//  5 REQ STEPS=0 -> DONE 2 cycles after accept, no MOVE/LOAD; REQ held during BUSY -> only one op.
//  6 TX_SYNC_RST during GAP of STEPS=4 op -> BUSY=0, MOVE=0, TX_DATA_0=F next cycle, no DONE.

Source files
------------

// File: rtl/pf_ddr4_cs_n_tx_ctrl_if.sv
// Signal bundle between the DDR4 CS0_N lane controller, the DFI/training fabric and the IOD lane.
// master = fabric/training/IOD side, slave = pf_ddr4_cs_n_tx_ctrl.
interface pf_ddr4_cs_n_tx_ctrl_if #(
    parameter int STEP_W = 8
);
    logic [3:0]        dfi_cs_n;
    logic              cs_oe;
    logic [3:0]        tx_data_0;
    logic [3:0]        oe_data_0;
    logic              adj_req;
    logic              adj_load;
    logic              adj_dir;
    logic [STEP_W-1:0] adj_steps;
    logic              adj_busy;
    logic              adj_done;
    logic              adj_err;
    logic [STEP_W-1:0] adj_count;
    logic              delay_line_move_0;
    logic              delay_line_direction_0;
    logic              delay_line_load_0;
    logic              delay_line_out_of_range_0;

    modport master (
        output dfi_cs_n, cs_oe, adj_req, adj_load, adj_dir, adj_steps, delay_line_out_of_range_0,
        input  tx_data_0, oe_data_0, adj_busy, adj_done, adj_err, adj_count,
               delay_line_move_0, delay_line_direction_0, delay_line_load_0
    );

    modport slave (
        input  dfi_cs_n, cs_oe, adj_req, adj_load, adj_dir, adj_steps, delay_line_out_of_range_0,
        output tx_data_0, oe_data_0, adj_busy, adj_done, adj_err, adj_count,
               delay_line_move_0, delay_line_direction_0, delay_line_load_0
    );
endinterface

// File: rtl/pf_ddr4_cs_n_tx_ctrl.sv
// Fabric-side driver for the DDR4 CS0_N IOD lane: pipelined CS_N/OE nibbles plus a
// req/busy/done sequencer for the lane's dynamic TX delay line (LOAD or N MOVE steps).
//
// state | meaning
// IDLE  | waiting for adj_req; request fields latched on accept
// SETUP | drive direction, pick LOAD / MOVE / immediate DONE
// LOAD  | one-cycle delay-line LOAD pulse
// MOVE  | one-cycle delay-line MOVE pulse, count incremented
// GAP   | MOVE_GAP settle cycles; out-of-range aborts here
// DONE  | one-cycle adj_done pulse
module pf_ddr4_cs_n_tx_ctrl #(
    parameter int PIPE_LAT = 2,
    parameter int MOVE_GAP = 4,
    parameter int STEP_W   = 8
) (
    input logic                   fab_clk,
    input logic                   tx_sync_rst,
    pf_ddr4_cs_n_tx_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        MOVE,
        GAP,
        DONE
    } state_t;

    localparam logic [3:0] GAP_INIT = 4'(MOVE_GAP - 1);

    logic [3:0]          tx_pipe [PIPE_LAT];
    logic [PIPE_LAT-1:0] oe_pipe;

    state_t            state;
    logic              busy;
    logic              done;
    logic              err;
    logic [STEP_W-1:0] count;
    logic              move;
    logic              load;
    logic              dir_out;
    logic              op_dir;
    logic              op_load;
    logic [STEP_W-1:0] op_steps;
    logic [3:0]        gap_cnt;

    // Reset fills the whole pipeline with deselect so the pad never glitches low.
    always_ff @(posedge fab_clk) begin
        if (tx_sync_rst) begin
            for (int i = 0; i < PIPE_LAT; i++) tx_pipe[i] <= 4'hF;
            oe_pipe <= '1;
        end else begin
            tx_pipe[0] <= bus.dfi_cs_n;
            oe_pipe[0] <= bus.cs_oe;
            for (int i = 1; i < PIPE_LAT; i++) begin
                tx_pipe[i] <= tx_pipe[i-1];
                oe_pipe[i] <= oe_pipe[i-1];
            end
        end
    end

    assign bus.tx_data_0 = tx_pipe[PIPE_LAT-1];
    assign bus.oe_data_0 = {4{oe_pipe[PIPE_LAT-1]}};

    always_ff @(posedge fab_clk) begin
        if (tx_sync_rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
            move     <= 1'b0;
            load     <= 1'b0;
            dir_out  <= 1'b0;
            op_dir   <= 1'b0;
            op_load  <= 1'b0;
            op_steps <= '0;
            gap_cnt  <= '0;
        end else begin
            move <= 1'b0;
            load <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.adj_req) begin
                        op_dir   <= bus.adj_dir;
                        op_load  <= bus.adj_load;
                        op_steps <= bus.adj_steps;
                        err      <= 1'b0;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    dir_out <= op_dir;
                    if (op_load) begin
                        load  <= 1'b1;
                        state <= LOAD;
                    end else if (op_steps == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        move  <= 1'b1;
                        count <= count + STEP_W'(1);
                        state <= MOVE;
                    end
                end
                LOAD, MOVE: begin
                    gap_cnt <= GAP_INIT;
                    state   <= GAP;
                end
                GAP: begin
                    if (bus.delay_line_out_of_range_0) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (gap_cnt == '0) begin
                        if (op_load || count == op_steps) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            move  <= 1'b1;
                            count <= count + STEP_W'(1);
                            state <= MOVE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                DONE: begin
                    busy    <= 1'b0;
                    dir_out <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.adj_busy               = busy;
    assign bus.adj_done               = done;
    assign bus.adj_err                = err;
    assign bus.adj_count              = count;
    assign bus.delay_line_move_0      = move;
    assign bus.delay_line_load_0      = load;
    assign bus.delay_line_direction_0 = dir_out;

endmodule
